// File: rtl/timer_1us_pulse.sv
// rtl/timer_1us_pulse.sv - free-running 1 us prescaler plus PERIOD_US timeout pulse
// Optional build macro TIMER_1US_TICK_OUT_EN adds the registered o_tick_1us output.
module timer_1us_pulse #(
  parameter int PERIOD_US  = 1000,
  parameter int CLK_PER_US = 25
) (
  input  logic i_clk_25MHz,
  input  logic i_reset,
`ifdef TIMER_1US_TICK_OUT_EN
  output logic o_tick_1us,
`endif
  output logic o_q
);

  localparam int PS_W = $clog2(CLK_PER_US + 1);
  localparam int US_W = $clog2(PERIOD_US + 1);
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_PER_US - 1);
  localparam logic [US_W-1:0] US_MAX = US_W'(PERIOD_US - 1);

  logic [PS_W-1:0] prescaler;
  logic [US_W-1:0] us_count;
  logic            us_tick;
  logic            us_wrap;

  assign us_tick = (prescaler == PS_MAX);
  assign us_wrap = (us_count == US_MAX);

  always_ff @(posedge i_clk_25MHz or posedge i_reset) begin
    if (i_reset) begin
      prescaler <= '0;
      us_count  <= '0;
      o_q       <= 1'b0;
    end else begin
      prescaler <= us_tick ? '0 : prescaler + PS_W'(1);
      if (us_tick) begin
        us_count <= us_wrap ? '0 : us_count + US_W'(1);
      end
      // Pulse lands on the same edge that wraps us_count, so periods never drift.
      o_q <= us_tick && us_wrap;
    end
  end

`ifdef TIMER_1US_TICK_OUT_EN
  always_ff @(posedge i_clk_25MHz or posedge i_reset) begin
    if (i_reset) begin
      o_tick_1us <= 1'b0;
    end else begin
      o_tick_1us <= us_tick;
    end
  end
`endif

endmodule

// File: tb/tb_timer_1us_pulse.sv
// tb/tb_timer_1us_pulse.sv - scoreboard bench for timer_1us_pulse (three parameter sets)
module tb_timer_1us_pulse;

  localparam int A_P = 1000, A_C = 25;
  localparam int B_P = 1,    B_C = 25;
  localparam int C_P = 7,    C_C = 1;

  logic i_clk_25MHz = 1'b0;
  logic i_reset     = 1'b1;
  logic q_a, q_b, q_c;
  logic tick_a, tick_b, tick_c;

  int vectors     = 0;
  int miscompares = 0;
  int edge_n      = 0;
  int cnt_a, cnt_b, cnt_c, tick_cnt;
  int exp_a[$];
  int exp_b[$];
  int exp_c[$];

  always #20 i_clk_25MHz = ~i_clk_25MHz;

  timer_1us_pulse #(.PERIOD_US(A_P), .CLK_PER_US(A_C)) dut (
    .i_clk_25MHz(i_clk_25MHz), .i_reset(i_reset),
`ifdef TIMER_1US_TICK_OUT_EN
    .o_tick_1us(tick_a),
`endif
    .o_q(q_a));

  timer_1us_pulse #(.PERIOD_US(B_P), .CLK_PER_US(B_C)) dut_b (
    .i_clk_25MHz(i_clk_25MHz), .i_reset(i_reset),
`ifdef TIMER_1US_TICK_OUT_EN
    .o_tick_1us(tick_b),
`endif
    .o_q(q_b));

  timer_1us_pulse #(.PERIOD_US(C_P), .CLK_PER_US(C_C)) dut_c (
    .i_clk_25MHz(i_clk_25MHz), .i_reset(i_reset),
`ifdef TIMER_1US_TICK_OUT_EN
    .o_tick_1us(tick_c),
`endif
    .o_q(q_c));

`ifndef TIMER_1US_TICK_OUT_EN
  assign tick_a = 1'b0;
  assign tick_b = 1'b0;
  assign tick_c = 1'b0;
`endif

  task automatic check_eq(input string tag, input longint obs, input longint req);
    vectors++;
    if (obs !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, obs, req, edge_n);
    end
  endtask

  // Push the expected pulse edges for a segment of n edges, then release reset.
  task automatic start_seg(input int n);
    exp_a.delete(); exp_b.delete(); exp_c.delete();
    edge_n = 0; cnt_a = 0; cnt_b = 0; cnt_c = 0; tick_cnt = 0;
    for (int e = A_P * A_C; e <= n; e += A_P * A_C) exp_a.push_back(e);
    for (int e = B_P * B_C; e <= n; e += B_P * B_C) exp_b.push_back(e);
    for (int e = C_P * C_C; e <= n; e += C_P * C_C) exp_c.push_back(e);
    @(negedge i_clk_25MHz);
    i_reset = 1'b0;
  endtask

  task automatic run_edges(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk_25MHz);
      #1;
      edge_n++;
      if (q_a) begin
        cnt_a++;
        if (exp_a.size() == 0) check_eq("a_spurious", edge_n, 0);
        else check_eq("a_pulse_edge", edge_n, exp_a.pop_front());
      end else if (exp_a.size() != 0 && exp_a[0] <= edge_n) begin
        check_eq("a_missed", 0, exp_a.pop_front());
      end
      if (q_b) begin
        cnt_b++;
        if (exp_b.size() == 0) check_eq("b_spurious", edge_n, 0);
        else check_eq("b_pulse_edge", edge_n, exp_b.pop_front());
      end else if (exp_b.size() != 0 && exp_b[0] <= edge_n) begin
        check_eq("b_missed", 0, exp_b.pop_front());
      end
      if (q_c) begin
        cnt_c++;
        if (exp_c.size() == 0) check_eq("c_spurious", edge_n, 0);
        else check_eq("c_pulse_edge", edge_n, exp_c.pop_front());
      end else if (exp_c.size() != 0 && exp_c[0] <= edge_n) begin
        check_eq("c_missed", 0, exp_c.pop_front());
      end
`ifdef TIMER_1US_TICK_OUT_EN
      check_eq("a_tick_phase", tick_a, (edge_n % A_C) == 0);
      check_eq("c_tick_phase", tick_c, 1);
      if (tick_a) tick_cnt++;
      if (q_a) begin
        check_eq("a_ticks_per_pulse", tick_cnt, A_P);
        tick_cnt = 0;
      end
`endif
    end
  endtask

  task automatic end_seg(input int n);
    check_eq("a_count", cnt_a, n / (A_P * A_C));
    check_eq("b_count", cnt_b, n / (B_P * B_C));
    check_eq("c_count", cnt_c, n / (C_P * C_C));
    check_eq("a_left", exp_a.size(), 0);
    check_eq("b_left", exp_b.size(), 0);
    check_eq("c_left", exp_c.size(), 0);
  endtask

  initial begin
    repeat (5) @(posedge i_clk_25MHz);
    #1;
    check_eq("rst_q", q_a, 0);
    check_eq("rst_prescaler", dut.prescaler, 0);
    check_eq("rst_us_count", dut.us_count, 0);
`ifdef TIMER_1US_TICK_OUT_EN
    check_eq("rst_tick", tick_a, 0);
`endif

    // Free run: four default pulses, spaced 25000 edges.
    start_seg(100000);
    run_edges(100000);
    end_seg(100000);

    // Asynchronous reset mid-period, between clock edges.
    i_reset = 1'b1;
    repeat (2) @(posedge i_clk_25MHz);
    start_seg(12000);
    run_edges(12000);
    end_seg(12000);
    #5 i_reset = 1'b1;
    #1;
    check_eq("async_q", q_a, 0);
    check_eq("async_prescaler", dut.prescaler, 0);
    check_eq("async_us_count", dut.us_count, 0);
    check_eq("async_b_prescaler", dut_b.prescaler, 0);
    repeat (3) @(posedge i_clk_25MHz);
    start_seg(25000);
    run_edges(25000);
    end_seg(25000);

    // Reset asserted in the cycle whose closing edge would raise the pulse.
    i_reset = 1'b1;
    repeat (2) @(posedge i_clk_25MHz);
    start_seg(24999);
    run_edges(24999);
    end_seg(24999);
    i_reset = 1'b1;
    #1;
    check_eq("pend_q_now", q_a, 0);
    @(posedge i_clk_25MHz);
    #1;
    check_eq("pend_no_pulse", q_a, 0);
    check_eq("pend_us_count", dut.us_count, 0);
    @(posedge i_clk_25MHz);
    start_seg(25000);
    run_edges(25000);
    end_seg(25000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
